// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus of the 16-bit core front end: instruction memory address/data,
// control FSM requests and the fetch unit's status outputs.
interface fetch_pc_unit_if;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        fetch_en;
    logic        redirect;
    logic [1:0]  redirect_sel;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic [4:0]  ras_count;
    logic        fault;

    modport master (
        input  pc_out, ir_out, ir_valid, ras_count, fault,
        output instr_in, fetch_en, redirect, redirect_sel
    );

    modport slave (
        output pc_out, ir_out, ir_valid, ras_count, fault,
        input  instr_in, fetch_en, redirect, redirect_sel
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and return-address stack of the
// multicycle core; redirects act only on an instruction currently held in IR.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 8
) (
    input logic            clk,
    input logic            reset,
    fetch_pc_unit_if.slave io_bus
);
    localparam int         PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [4:0] CNT_MAX = 5'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_HOLD  = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic        r_ir_valid, w_ir_valid_nxt;
    logic [4:0]  r_ras_count, w_ras_count_nxt;
    logic        r_fault, w_fault_nxt;
    logic        w_push;
    logic [15:0] r_ras [RAS_DEPTH];

    logic [PTR_W-1:0] w_push_idx;
    logic [PTR_W-1:0] w_pop_idx;
    logic [15:0]      w_br_off;

    assign w_push_idx = r_ras_count[PTR_W-1:0];
    assign w_pop_idx  = PTR_W'(r_ras_count - 5'd1);
    assign w_br_off   = {{10{r_ir[5]}}, r_ir[5:0]};

    // Next-state and next-register computation for fetch, redirect and fault.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_ir_valid_nxt  = r_ir_valid;
        w_ras_count_nxt = r_ras_count;
        w_fault_nxt     = r_fault;
        w_push          = 1'b0;
        case (r_state)
            S_EMPTY, S_HOLD: begin
                if ((r_state == S_HOLD) && io_bus.redirect) begin
                    // Default is a successful redirect; stack errors override below.
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = S_EMPTY;
                    case (io_bus.redirect_sel)
                        2'b00: w_pc_nxt = r_pc + w_br_off;
                        2'b01: w_pc_nxt = {4'b0000, r_ir[11:0]};
                        2'b10: begin
                            if (r_ras_count < CNT_MAX) begin
                                w_push          = 1'b1;
                                w_ras_count_nxt = r_ras_count + 5'd1;
                                w_pc_nxt        = {4'b0000, r_ir[11:0]};
                            end else begin
                                w_fault_nxt = 1'b1;
                                w_state_nxt = S_FAULT;
                            end
                        end
                        2'b11: begin
                            if (r_ras_count != 5'd0) begin
                                w_ras_count_nxt = r_ras_count - 5'd1;
                                w_pc_nxt        = r_ras[w_pop_idx];
                            end else begin
                                w_fault_nxt = 1'b1;
                                w_state_nxt = S_FAULT;
                            end
                        end
                        default: w_pc_nxt = r_pc;
                    endcase
                end else if (io_bus.fetch_en && !io_bus.redirect) begin
                    w_ir_nxt       = io_bus.instr_in;
                    w_pc_nxt       = r_pc + 16'd1;
                    w_ir_valid_nxt = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_FAULT: begin
                w_ir_valid_nxt = 1'b0;
                w_fault_nxt    = 1'b1;
            end
            default: begin
                w_ir_valid_nxt = 1'b0;
                w_state_nxt    = S_EMPTY;
            end
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_pc        <= RESET_PC;
            r_ir        <= 16'h0000;
            r_ir_valid  <= 1'b0;
            r_ras_count <= 5'd0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_ras_count <= w_ras_count_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_push_idx] <= r_pc;
        end
    end

    assign io_bus.pc_out    = r_pc;
    assign io_bus.ir_out    = r_ir;
    assign io_bus.ir_valid  = r_ir_valid;
    assign io_bus.ras_count = r_ras_count;
    assign io_bus.fault     = r_fault;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against a queue-based
// behavioural model of the PC, IR and return-address stack.
module tb_fetch_pc_unit;
    localparam int RAS_DEPTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_pc_unit_if bus_if ();

    fetch_pc_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk    (clk),
        .reset  (rst),
        .io_bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic        m_valid;
    logic        m_fault;
    logic [15:0] m_ras[$];

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_ir    = 16'h0000;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_edge(input logic f, input logic r, input logic [1:0] s, input logic [15:0] ins);
        int off;
        if (m_fault) return;
        if (r && m_valid) begin
            off = (m_ir[5:0] >= 6'd32) ? int'(m_ir[5:0]) - 64 : int'(m_ir[5:0]);
            m_valid = 1'b0;
            if (s == 2'd0) m_pc = 16'(int'(m_pc) + off);
            else if (s == 2'd1) m_pc = m_ir & 16'h0FFF;
            else if (s == 2'd2) begin
                if (m_ras.size() < RAS_DEPTH) begin
                    m_ras.push_back(m_pc);
                    m_pc = m_ir & 16'h0FFF;
                end else m_fault = 1'b1;
            end else begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else m_fault = 1'b1;
            end
        end else if (f && !r) begin
            m_ir    = ins;
            m_pc    = m_pc + 16'd1;
            m_valid = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"}, bus_if.pc_out, m_pc);
        chk({tag, "_ir"}, bus_if.ir_out, m_ir);
        chk({tag, "_valid"}, {15'd0, bus_if.ir_valid}, {15'd0, m_valid});
        chk({tag, "_cnt"}, {11'd0, bus_if.ras_count}, 16'(m_ras.size()));
        chk({tag, "_fault"}, {15'd0, bus_if.fault}, {15'd0, m_fault});
    endtask

    task automatic step(input string tag, input logic f, input logic r, input logic [1:0] s, input logic [15:0] ins);
        bus_if.fetch_en     = f;
        bus_if.redirect     = r;
        bus_if.redirect_sel = s;
        bus_if.instr_in     = ins;
        @(posedge clk);
        model_edge(f, r, s, ins);
        #1;
        bus_if.fetch_en = 1'b0;
        bus_if.redirect = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.fetch_en     = 1'b1;
        bus_if.redirect     = 1'b0;
        bus_if.redirect_sel = 2'b00;
        bus_if.instr_in     = 16'h3001;
        model_reset();
        @(posedge clk);
        #1;
        check_all("t1_inreset");
        rst = 1'b0;
        step("t1_fetch", 1'b1, 1'b0, 2'b00, 16'h3001);
        chk("t1_ir_const", bus_if.ir_out, 16'h3001);
        chk("t1_pc_const", bus_if.pc_out, 16'h0001);

        step("t2_f1", 1'b1, 1'b0, 2'b00, 16'h1004);
        step("t2_jmp", 1'b0, 1'b1, 2'b01, 16'h0000);
        step("t2_f2", 1'b1, 1'b0, 2'b00, 16'hA281);
        step("t2_beq", 1'b0, 1'b1, 2'b00, 16'h0000);
        chk("t2_beq_pos", bus_if.pc_out, 16'h0006);
        step("t2_second_redir", 1'b0, 1'b1, 2'b01, 16'h0000);
        chk("t2_ignored", bus_if.pc_out, 16'h0006);
        step("t2_f3", 1'b1, 1'b0, 2'b00, 16'h1004);
        step("t2_jmp2", 1'b0, 1'b1, 2'b01, 16'h0000);
        step("t2_f4", 1'b1, 1'b0, 2'b00, 16'hA2BE);
        step("t2_beq_neg", 1'b0, 1'b1, 2'b00, 16'h0000);
        chk("t2_beq_neg_pc", bus_if.pc_out, 16'h0003);

        step("t3_f0", 1'b1, 1'b0, 2'b00, 16'h1006);
        step("t3_jmp", 1'b0, 1'b1, 2'b01, 16'h0000);
        step("t3_fcall", 1'b1, 1'b0, 2'b00, 16'hD004);
        step("t3_call", 1'b0, 1'b1, 2'b10, 16'h0000);
        chk("t3_call_pc", bus_if.pc_out, 16'h0004);
        chk("t3_call_cnt", {11'd0, bus_if.ras_count}, 16'd1);
        step("t3_fret", 1'b1, 1'b0, 2'b00, 16'hE000);
        step("t3_ret", 1'b0, 1'b1, 2'b11, 16'h0000);
        chk("t3_ret_pc", bus_if.pc_out, 16'h0007);

        step("t4_fret", 1'b1, 1'b0, 2'b00, 16'hE000);
        step("t4_underflow", 1'b0, 1'b1, 2'b11, 16'h0000);
        chk("t4_fault", {15'd0, bus_if.fault}, 16'd1);
        chk("t4_pc", bus_if.pc_out, 16'h0008);
        step("t4_frozen", 1'b1, 1'b0, 2'b00, 16'h1234);
        chk("t4_frozen_ir", bus_if.ir_out, 16'hE000);
        do_reset("t4_reset");

        for (int i = 0; i < 9; i++) begin
            step("t5_fcall", 1'b1, 1'b0, 2'b00, 16'hD010);
            step("t5_call", 1'b0, 1'b1, 2'b10, 16'h0000);
            if (i == 7) chk("t5_full_cnt", {11'd0, bus_if.ras_count}, 16'd8);
        end
        chk("t5_overflow", {15'd0, bus_if.fault}, 16'd1);
        do_reset("t5_reset");

        step("t6_f", 1'b1, 1'b0, 2'b00, 16'hC003);
        step("t6_both", 1'b1, 1'b1, 2'b01, 16'h5555);
        chk("t6_both_pc", bus_if.pc_out, 16'h0003);
        chk("t6_both_ir", bus_if.ir_out, 16'hC003);
        do_reset("t6_reset");
        step("t6_fwrap", 1'b1, 1'b0, 2'b00, 16'h003E);
        step("t6_to_ffff", 1'b0, 1'b1, 2'b00, 16'h0000);
        chk("t6_ffff", bus_if.pc_out, 16'hFFFF);
        step("t6_wrap", 1'b1, 1'b0, 2'b00, 16'h0001);
        chk("t6_wrap_pc", bus_if.pc_out, 16'h0000);
        step("t6_f2", 1'b1, 1'b0, 2'b00, 16'h0002);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t6_async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            if (($urandom_range(0, 59) == 0) || (m_fault && $urandom_range(0, 3) == 0)) begin
                do_reset("rnd_reset");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 2) == 0),
                     2'($urandom_range(0, 3)),
                     16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
